// File: rtl/alu_ctrl_pkg.sv
// Shared opcode constants, FSM encoding and opcode legality check for the ALU arbiter.
package alu_ctrl_pkg;

    localparam int unsigned WIDTH = 7;
    localparam int unsigned OPW   = 4;
    localparam int unsigned CNTW  = 8;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;
    localparam logic [3:0] OP_ROL = 4'b1010;
    localparam logic [3:0] OP_ROR = 4'b1011;
    localparam logic [3:0] OP_MUL = 4'b1110;
    localparam logic [3:0] OP_DIV = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    // True when the opcode is one the ALU implements.
    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_MUL, OP_DIV: legal = 1'b1;
            default:                                          legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_arbiter_ctrl_if.sv
// Requester, response and ALU-side signals of the ALU arbiter, bundled in one interface.
interface alu_arbiter_ctrl_if #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned OPW   = 4,
    parameter int unsigned CNTW  = 8
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [2*OPW-1:0]   req_op;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [OPW-1:0]     alu_opcode;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_carry;
    logic               alu_zero;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [WIDTH-1:0]   rsp_result;
    logic               rsp_carry;
    logic               rsp_zero;
    logic               rsp_err;
    logic [2*CNTW-1:0]  done_cnt;

    // Environment side: requesters, response consumer and the ALU itself.
    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
               alu_result, alu_carry, alu_zero,
        input  req_ready, alu_a, alu_b, alu_opcode,
               rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_err, done_cnt
    );

    // Controller side.
    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
               alu_result, alu_carry, alu_zero,
        output req_ready, alu_a, alu_b, alu_opcode,
               rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_err, done_cnt
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: grants the lone requester, or the favoured one on a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_grant
);
    logic r_prio;   // requester favoured on a tie (the one not served last)

    // Combinational one-hot grant.
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_prio ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

    // After an accepted grant, favour the other requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (i_accept) begin
            r_prio <= ~o_grant[1];
        end
    end
endmodule

// File: rtl/alu_arbiter_ctrl.sv
// Shares one external ALU between two requesters; one operation in flight at a time.
module alu_arbiter_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = alu_ctrl_pkg::WIDTH,
    parameter int unsigned OPW   = alu_ctrl_pkg::OPW,
    parameter int unsigned CNTW  = alu_ctrl_pkg::CNTW
) (
    input  logic           clk,
    input  logic           rst,
    alu_arbiter_ctrl_if.slave bus
);
    state_t           r_state;
    logic             r_id;
    logic             r_err;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [OPW-1:0]   r_alu_op;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_carry;
    logic             r_rsp_zero;
    logic             r_rsp_err;
    logic [CNTW-1:0]  r_cnt [2];

    logic [1:0]       w_grant;
    logic             w_hs;
    logic             w_id;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [OPW-1:0]   w_op;
    logic             w_err;

    // Arbitration is only offered while idle.
    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    ((r_state == ST_IDLE) ? bus.req_valid : 2'b00),
        .i_accept (w_hs),
        .o_grant  (w_grant)
    );

    assign w_hs  = |w_grant;
    assign w_id  = w_grant[1];
    assign w_a   = w_id ? bus.req_a[2*WIDTH-1 -: WIDTH] : bus.req_a[WIDTH-1:0];
    assign w_b   = w_id ? bus.req_b[2*WIDTH-1 -: WIDTH] : bus.req_b[WIDTH-1:0];
    assign w_op  = w_id ? bus.req_op[2*OPW-1 -: OPW]    : bus.req_op[OPW-1:0];
    assign w_err = !is_legal_op(4'(w_op)) || ((4'(w_op) == OP_DIV) && (w_b == '0));

    // Control FSM: accept, drive the ALU, capture its outputs, hold the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_id         <= 1'b0;
            r_err        <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_cnt[0]     <= '0;
            r_cnt[1]     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_id  <= w_id;
                        r_err <= w_err;
                        // Rejected ops never reach the ALU, so its inputs keep their last value.
                        if (!w_err) begin
                            r_alu_a  <= w_a;
                            r_alu_b  <= w_b;
                            r_alu_op <= w_op;
                        end
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_err) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_id     <= r_id;
                        r_rsp_result <= '0;
                        r_rsp_carry  <= 1'b0;
                        r_rsp_zero   <= 1'b0;
                        r_rsp_err    <= 1'b1;
                        r_state      <= ST_RESP;
                    end else begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    r_rsp_valid  <= 1'b1;
                    r_rsp_id     <= r_id;
                    r_rsp_result <= bus.alu_result;
                    r_rsp_carry  <= bus.alu_carry;
                    r_rsp_zero   <= bus.alu_zero;
                    r_rsp_err    <= 1'b0;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (r_cnt[r_id] != '1) begin
                            r_cnt[r_id] <= r_cnt[r_id] + CNTW'(1);
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = w_grant;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_opcode = r_alu_op;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_carry  = r_rsp_carry;
    assign bus.rsp_zero   = r_rsp_zero;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.done_cnt   = {r_cnt[1], r_cnt[0]};
endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Bench for alu_arbiter_ctrl: directed and random ops against a transaction-level model.
module tb_alu_arbiter_ctrl;
    localparam int unsigned W    = 7;
    localparam int unsigned OPW  = 4;
    localparam int unsigned CNTW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_ctrl_if #(.WIDTH(W), .OPW(OPW), .CNTW(CNTW)) bus ();

    alu_arbiter_ctrl #(.WIDTH(W), .OPW(OPW), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Model state: favoured requester on a tie, completion counts, last ALU inputs.
    int           m_prio;
    int           m_cnt [2];
    logic [W-1:0] m_alu_a, m_alu_b;
    logic [3:0]   m_alu_op;

    logic [W-1:0] p_a [2];
    logic [W-1:0] p_b [2];
    logic [3:0]   p_op [2];

    // Behavioural ALU: returns {carry, zero, result}.
    function automatic logic [W+1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] op);
        logic [W-1:0]   r;
        logic           c;
        logic [W:0]     t;
        logic [2*W-1:0] p;
        r = '0; c = 1'b0;
        case (op)
            4'b0000: begin t = {1'b0, a} + {1'b0, b}; r = t[W-1:0]; c = t[W]; end
            4'b0001: begin t = {1'b0, a} - {1'b0, b}; r = t[W-1:0]; c = t[W]; end
            4'b0010: r = a & b;
            4'b0011: r = a | b;
            4'b0100: r = a ^ b;
            4'b1000: begin r = {a[W-2:0], 1'b0};    c = a[W-1]; end
            4'b1001: begin r = {1'b0, a[W-1:1]};    c = a[0];   end
            4'b1010: begin r = {a[W-2:0], a[W-1]};  c = a[W-1]; end
            4'b1011: begin r = {a[0], a[W-1:1]};    c = a[0];   end
            4'b1110: begin p = a * b; r = p[W-1:0]; c = |p[2*W-1:W]; end
            4'b1111: r = (b == '0) ? '0 : a / b;
            default: r = '0;
        endcase
        return {c, (r == '0), r};
    endfunction

    function automatic bit op_ok(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10, 4'd11, 4'd14, 4'd15};
    endfunction

    // The ALU seen by the controller.
    always_comb begin
        {bus.alu_carry, bus.alu_zero, bus.alu_result} = alu_ref(bus.alu_a, bus.alu_b, bus.alu_opcode);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*CNTW-1:0] exp_cnt();
        return {CNTW'(m_cnt[1]), CNTW'(m_cnt[0])};
    endfunction

    task automatic model_reset();
        m_prio = 0; m_cnt[0] = 0; m_cnt[1] = 0;
        m_alu_a = '0; m_alu_b = '0; m_alu_op = '0;
    endtask

    // Checks every output is at its reset value (no request pending).
    task automatic chk_reset_outputs();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_opcode}), 32'd0);
        chk("rst_rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_carry,
                             bus.rsp_zero, bus.rsp_err}), 32'd0);
        chk("rst_done_cnt", 32'(bus.done_cnt), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        model_reset();
    endtask

    // One full transaction: offer vmask, check grant, latency, response, counters.
    task automatic txn(input logic [1:0] vmask, input int rdy_delay);
        int           id, k, lat;
        bit           err;
        logic [W+1:0] e;
        id = (vmask == 2'b11) ? m_prio : (vmask[1] ? 1 : 0);
        @(negedge clk);
        bus.req_valid = vmask;
        bus.req_a  = {p_a[1], p_a[0]};
        bus.req_b  = {p_b[1], p_b[0]};
        bus.req_op = {p_op[1], p_op[0]};
        #1 chk("grant", 32'(bus.req_ready), 32'(2'b01 << id));
        @(posedge clk);
        m_prio = (id == 0) ? 1 : 0;
        err = !op_ok(p_op[id]) || (p_op[id] == 4'b1111 && p_b[id] == '0);
        e   = err ? '0 : alu_ref(p_a[id], p_b[id], p_op[id]);
        if (!err) begin
            m_alu_a = p_a[id]; m_alu_b = p_b[id]; m_alu_op = p_op[id];
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                chk("busy_req_ready", 32'(bus.req_ready), 32'd0);
                chk("alu_inputs", 32'({bus.alu_a, bus.alu_b, bus.alu_opcode}),
                    32'({m_alu_a, m_alu_b, m_alu_op}));
                bus.req_valid = 2'b00;
            end
        end while (!bus.rsp_valid && k < 8);
        lat = err ? 2 : 3;
        chk("latency", 32'(k), 32'(lat));
        chk("rsp_id", 32'(bus.rsp_id), 32'(id));
        chk("rsp_err", 32'(bus.rsp_err), 32'(err));
        chk("rsp_data", 32'({bus.rsp_carry, bus.rsp_zero, bus.rsp_result}), 32'(e));
        chk("cnt_before", 32'(bus.done_cnt), 32'(exp_cnt()));
        // Stall the consumer with both requesters clamouring.
        for (int i = 0; i < rdy_delay; i++) begin
            bus.req_valid = 2'b11;
            @(negedge clk);
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
            chk("hold_rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_carry,
                                  bus.rsp_zero, bus.rsp_result}),
                32'({1'b1, 1'(id), err, e}));
            chk("hold_cnt", 32'(bus.done_cnt), 32'(exp_cnt()));
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        if (m_cnt[id] < 255) m_cnt[id]++;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        chk("cnt_after", 32'(bus.done_cnt), 32'(exp_cnt()));
    endtask

    task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [3:0] op);
        p_a[id] = a; p_b[id] = b; p_op[id] = op;
    endtask

    initial begin
        bus.req_valid = 2'b00;
        bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) set_req(i, '0, '0, '0);

        // Power-on reset.
        do_reset();

        // Single add on requester 0.
        set_req(0, 7'b0001111, 7'b0000001, 4'b0000);
        txn(2'b01, 0);

        // Tie from a fresh reset: requester 0 first, then alternation.
        do_reset();
        set_req(0, 7'd15, 7'd1, 4'b0001);
        set_req(1, 7'b0101010, 7'b1001100, 4'b0010);
        txn(2'b11, 0);
        txn(2'b11, 0);
        txn(2'b11, 0);
        txn(2'b11, 0);

        // Illegal opcode on requester 1.
        set_req(1, 7'd33, 7'd7, 4'b0101);
        txn(2'b10, 0);

        // Divide by zero, then a valid divide.
        set_req(0, 7'b0001000, 7'b0000000, 4'b1111);
        txn(2'b01, 0);
        set_req(0, 7'b0001000, 7'b0000010, 4'b1111);
        txn(2'b01, 0);

        // Consumer back-pressure for 5 cycles.
        set_req(0, 7'd100, 7'd27, 4'b0000);
        txn(2'b01, 5);

        // Reset while the op is in CAPTURE.
        @(negedge clk);
        set_req(0, 7'd5, 7'd9, 4'b0011);
        bus.req_valid = 2'b01;
        bus.req_a = {p_a[1], p_a[0]}; bus.req_b = {p_b[1], p_b[0]}; bus.req_op = {p_op[1], p_op[0]};
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        model_reset();

        // 256 ops on requester 0: counter saturates at 255.
        for (int n = 0; n < 256; n++) begin
            set_req(0, W'($urandom), W'($urandom), 4'($urandom));
            txn(2'b01, int'($urandom_range(0, 1)));
        end
        chk("cnt0_saturated", 32'(bus.done_cnt[CNTW-1:0]), 32'd255);

        // Random traffic on both requesters.
        for (int n = 0; n < 60; n++) begin
            logic [1:0] m;
            for (int i = 0; i < 2; i++) set_req(i, W'($urandom), W'($urandom), 4'($urandom));
            m = 2'($urandom_range(1, 3));
            txn(m, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
